// File: rtl/jtcop_irq_pkg.sv
// Shared constants and helpers for the jtcop 68000 interrupt controller.
package jtcop_irq_pkg;

  localparam logic [2:0] IPL_NONE = 3'b111;
  localparam logic [2:0] FC_IACK  = 3'b111;
  localparam int         MAX_SRC  = 8;

  // Returns the 3-bit IPL level assigned to source i in a packed level vector
  function automatic logic [2:0] lvl_of(input logic [3*MAX_SRC-1:0] levels, input int i);
    return levels[3*i +: 3];
  endfunction

endpackage

// File: rtl/jtcop_irq_prienc.sv
// Priority encoder: highest level among active sources, plus the lowest-index
// active source whose level equals the query.
module jtcop_irq_prienc
  import jtcop_irq_pkg::*;
#(
  parameter int NSRC = 4
) (
  input  logic [NSRC-1:0]   active,
  input  logic [3*NSRC-1:0] levels,
  input  logic [2:0]        query,
  output logic [2:0]        lvl,
  output logic [NSRC-1:0]   winner
);

  logic [3*MAX_SRC-1:0] levels_ext;
  logic                 found;

  assign levels_ext = (3*MAX_SRC)'(levels);

  always_comb begin
    lvl    = '0;
    winner = '0;
    found  = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      // strict compare keeps the lower index on equal levels
      if (active[i] && (lvl_of(levels_ext, i) > lvl)) lvl = lvl_of(levels_ext, i);
      if (!found && active[i] && (lvl_of(levels_ext, i) == query)) begin
        winner[i] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/jtcop_irqctl.sv
// Parametrised 68000 interrupt controller with per-source level/edge/polarity/mask.
// Define JTCOP_IRQ_AUTOCLR_EN to clear the acknowledged edge source on IACK.
module jtcop_irqctl
  import jtcop_irq_pkg::*;
#(
  parameter int                NSRC   = 4,
  parameter logic [3*NSRC-1:0] LEVELS = {3'd6, 3'd5, 3'd4, 3'd1},
  parameter logic [NSRC-1:0]   EDGE   = 4'b1111,
  parameter logic [NSRC-1:0]   POL    = 4'b1011
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [NSRC-1:0] src,
  input  logic [NSRC-1:0] clr,
  input  logic            mask_we,
  input  logic [NSRC-1:0] mask_din,
  input  logic            ASn,
  input  logic [2:0]      FC,
  input  logic [2:0]      A,
  output logic [2:0]      IPLn,
  output logic            VPAn,
  output logic [NSRC-1:0] pending,
  output logic [NSRC-1:0] mask
);

  if (NSRC < 1 || NSRC > MAX_SRC) begin : g_bad_nsrc
    $fatal(1, "jtcop_irqctl: NSRC must be within 1..8");
  end

  logic [NSRC-1:0] s;
  logic [NSRC-1:0] src_l_q, src_l_d;
  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] mask_q, mask_d;
  logic [2:0]      ipl_q, ipl_d;
  logic [NSRC-1:0] lvl_en;
  logic [NSRC-1:0] active;
  logic [NSRC-1:0] auto_clr;
  logic [2:0]      lvl;
  logic [NSRC-1:0] unused_ipl_win;
  logic            iack;

  always_comb begin
    lvl_en = '0;
    for (int i = 0; i < NSRC; i++) lvl_en[i] = (lvl_of((3*MAX_SRC)'(LEVELS), i) != 3'd0);
  end

  assign s       = src ^ ~POL;
  assign pending = (EDGE & pend_q) | (~EDGE & s);
  assign active  = pending & mask_q & lvl_en;
  assign iack    = ~ASn & (FC == FC_IACK);
  assign VPAn    = ~iack;
  assign IPLn    = ipl_q;
  assign mask    = mask_q;

  jtcop_irq_prienc #(.NSRC(NSRC)) u_ipl_enc (
    .active (active),
    .levels (LEVELS),
    .query  (3'd0),
    .lvl    (lvl),
    .winner (unused_ipl_win)
  );

`ifdef JTCOP_IRQ_AUTOCLR_EN
  logic            iack_q, iack_d;
  logic [NSRC-1:0] ack_win;
  logic [2:0]      unused_ack_lvl;

  // only edge sources are candidates; level sources follow their input
  jtcop_irq_prienc #(.NSRC(NSRC)) u_ack_enc (
    .active (active & EDGE),
    .levels (LEVELS),
    .query  (A),
    .lvl    (unused_ack_lvl),
    .winner (ack_win)
  );

  assign iack_d   = iack;
  assign auto_clr = (iack && !iack_q) ? ack_win : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) iack_q <= 1'b0;
    else       iack_q <= iack_d;
  end
`else
  logic [2:0] unused_a;

  assign unused_a = A;
  assign auto_clr = '0;
`endif

  always_comb begin
    src_l_d = s;
    // a new edge wins over a clear arriving in the same cycle
    pend_d  = EDGE & ((pend_q & ~(clr | auto_clr)) | (s & ~src_l_q));
    mask_d  = mask_we ? mask_din : mask_q;
    ipl_d   = ~lvl;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      src_l_q <= '0;
      pend_q  <= '0;
      mask_q  <= '1;
      ipl_q   <= IPL_NONE;
    end else begin
      src_l_q <= src_l_d;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      ipl_q   <= ipl_d;
    end
  end

endmodule

// File: tb/tb_jtcop_irqctl.sv
// Self-checking bench for jtcop_irqctl: directed scenarios plus random traffic
// compared each cycle against a behavioural model.
module tb_jtcop_irqctl;

  localparam logic [3:0]  EDGE_P = 4'b1011;
  localparam logic [3:0]  POL_P  = 4'b1011;
  localparam logic [3:0]  IDLE   = 4'b0100;
  localparam logic [11:0] LEV_P  = {3'd6, 3'd5, 3'd4, 3'd1};

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] src, clr, mask_din;
  logic       mask_we, ASn;
  logic [2:0] FC, A;
  logic [2:0] IPLn;
  logic       VPAn;
  logic [3:0] pending, mask;

  int lev [4] = '{1, 4, 5, 6};
  int n_chk  = 0;
  int n_pass = 0;

  logic [3:0] m_pend_e, m_sl, m_mask;
  logic [2:0] m_ipl;
  logic       m_iack_q;

  jtcop_irqctl #(
    .NSRC(4), .LEVELS(LEV_P), .EDGE(EDGE_P), .POL(POL_P)
  ) dut (
    .clk(clk), .rstn(rstn), .src(src), .clr(clr),
    .mask_we(mask_we), .mask_din(mask_din),
    .ASn(ASn), .FC(FC), .A(A),
    .IPLn(IPLn), .VPAn(VPAn), .pending(pending), .mask(mask)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [3:0] m_pending();
    logic [3:0] s;
    s = src ^ ~POL_P;
    return (EDGE_P & m_pend_e) | (~EDGE_P & s);
  endfunction

  function automatic logic [2:0] m_lvl(input logic [3:0] act);
    int best = 0;
    for (int i = 0; i < 4; i++) if (act[i] && lev[i] > best) best = lev[i];
    return 3'(best);
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_pend_e <= '0;
      m_sl     <= '0;
      m_mask   <= '1;
      m_ipl    <= 3'b111;
      m_iack_q <= 1'b0;
    end else begin : model_step
      logic [3:0] s, ac, act;
      logic       iack;
      s    = src ^ ~POL_P;
      act  = m_pending() & m_mask;
      iack = !ASn && (FC == 3'b111);
      ac   = '0;
`ifdef JTCOP_IRQ_AUTOCLR_EN
      if (iack && !m_iack_q)
        for (int i = 0; i < 4; i++)
          if (ac == 4'd0 && EDGE_P[i] && act[i] && lev[i] == int'(A)) ac[i] = 1'b1;
`endif
      m_pend_e <= EDGE_P & ((m_pend_e & ~(clr | ac)) | (s & ~m_sl));
      m_sl     <= s;
      if (mask_we) m_mask <= mask_din;
      m_ipl    <= ~m_lvl(act);
      m_iack_q <= iack;
    end
  end

  always @(negedge clk) begin
    if (rstn) begin : compare
      logic exp_vpa;
      exp_vpa = !(!ASn && (FC == 3'b111));
      chk("ipl", 8'(IPLn), 8'(m_ipl));
      chk("vpa", 8'(VPAn), 8'(exp_vpa));
      chk("pending", 8'(pending), 8'(m_pending()));
      chk("mask", 8'(mask), 8'(m_mask));
    end
  end

  initial begin
    rstn = 1'b0; src = IDLE; clr = '0; mask_we = 1'b0; mask_din = '0;
    ASn = 1'b1; FC = 3'd0; A = 3'd0;
    repeat (3) cyc();
    chk("rst_ipl", 8'(IPLn), 8'h7);
    chk("rst_pending", 8'(pending), 8'h0);
    chk("rst_vpa", 8'(VPAn), 8'h1);
    chk("rst_mask", 8'(mask), 8'hf);
    rstn = 1'b1;

    // one-clock pulse on the level-6 edge source
    src[3] = 1'b1; cyc(); src[3] = 1'b0;
    chk("t1_pend3", 8'(pending[3]), 8'h1);
    chk("t1_ipl_early", 8'(IPLn), 8'h7);
    cyc();
    chk("t1_ipl6", 8'(IPLn), 8'h1);
    repeat (3) cyc();
    chk("t1_hold", 8'(IPLn), 8'h1);
    clr[3] = 1'b1; cyc(); clr[3] = 1'b0;
    chk("t1_clr_pend", 8'(pending[3]), 8'h0);
    cyc();
    chk("t1_ipl_none", 8'(IPLn), 8'h7);

    // level 4 edge and level 5 active-low level source together
    src[1] = 1'b1; src[2] = 1'b0; cyc(); cyc();
    chk("t2_ipl5", 8'(IPLn), 8'h2);
    src[2] = 1'b1; cyc();
    chk("t2_ipl4", 8'(IPLn), 8'h3);
    src[1] = 1'b0; clr[1] = 1'b1; cyc(); clr[1] = 1'b0; cyc();
    chk("t2_ipl_none", 8'(IPLn), 8'h7);

    // level source ignores clr
    src[2] = 1'b0; clr[2] = 1'b1; cyc(); clr[2] = 1'b0;
    chk("t3_pend2", 8'(pending[2]), 8'h1);
    cyc();
    chk("t3_ipl5", 8'(IPLn), 8'h2);
    src[2] = 1'b1; #1;
    chk("t3_pend2_live", 8'(pending[2]), 8'h0);
    cyc();
    chk("t3_ipl_none", 8'(IPLn), 8'h7);

    // simultaneous edge and clear, then masking
    src[0] = 1'b1; clr[0] = 1'b1; cyc(); src[0] = 1'b0; clr[0] = 1'b0;
    chk("t4_set_wins", 8'(pending[0]), 8'h1);
    mask_we = 1'b1; mask_din = 4'b1110; cyc(); mask_we = 1'b0; cyc();
    chk("t4_masked_ipl", 8'(IPLn), 8'h7);
    chk("t4_masked_pend", 8'(pending[0]), 8'h1);
    mask_we = 1'b1; mask_din = 4'b1111; cyc(); mask_we = 1'b0; cyc();
    chk("t4_unmasked_ipl", 8'(IPLn), 8'h6);
    clr[0] = 1'b1; cyc(); clr[0] = 1'b0; cyc();

    // interrupt acknowledge at level 6
    src[3] = 1'b1; cyc(); src[3] = 1'b0; cyc();
    chk("t5_ipl6", 8'(IPLn), 8'h1);
    ASn = 1'b0; FC = 3'b111; A = 3'd6; #1;
    chk("t5_vpa", 8'(VPAn), 8'h0);
    cyc();
`ifdef JTCOP_IRQ_AUTOCLR_EN
    chk("t5_autoclr_pend", 8'(pending[3]), 8'h0);
    cyc();
    chk("t5_autoclr_ipl", 8'(IPLn), 8'h7);
`else
    chk("t5_keep_pend", 8'(pending[3]), 8'h1);
    cyc();
    chk("t5_keep_ipl", 8'(IPLn), 8'h1);
`endif
    ASn = 1'b1; FC = 3'd0; A = 3'd0;
    clr[3] = 1'b1; cyc(); clr[3] = 1'b0; cyc();

    // asynchronous reset with two requests latched
    src[0] = 1'b1; src[3] = 1'b1; cyc(); src = IDLE; cyc();
    chk("t6_pre_pend", 8'(pending), 8'h9);
    rstn = 1'b0; #1;
    chk("t6_rst_ipl", 8'(IPLn), 8'h7);
    chk("t6_rst_pend", 8'(pending), 8'h0);
    cyc();
    rstn = 1'b1;

    for (int n = 0; n < 3000; n++) begin
      src = src ^ 4'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15));
      clr = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      mask_we  = ($urandom_range(0, 15) == 0);
      mask_din = 4'($urandom_range(0, 15));
      ASn = ($urandom_range(0, 5) != 0);
      FC  = ($urandom_range(0, 1) == 0) ? 3'b111 : 3'($urandom_range(0, 7));
      A   = 3'($urandom_range(0, 7));
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
